// File: rtl/dcache_controller.sv
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache. It sits between the
// core's load/store stage and a 128-bit block memory, and serves 32-bit word
// accesses.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   cpu_read/cpu_write  word load / store request (both high = no request)
//   cpu_address         byte address: [3:2] word, [3+INDEX_W:4] index, rest tag
//   cpu_writedata       store data
//   cpu_readdata        load data, valid while cpu_busywait=0 on a read
//   cpu_busywait        stall to the core
//   mem_read/mem_write  block fetch / writeback request (Moore, never both)
//   mem_address         28-bit block address
//   mem_writedata       victim block being written back
//   mem_readdata        fetched block
//   mem_busywait        memory busy; low = access completes this cycle
//   state_debug         current FSM state (IDLE=0 WRITEBACK=1 ALLOCATE=2 UPDATE=3)
//
// Handshake: a request (cpu side or mem side) is held steady for as long as
// the responder's busywait is high. It is complete on the rising edge where
// busywait is sampled low. The requester drops or replaces it right after
// that edge, so a completed request is never seen twice.
module dcache_controller #(
  parameter int NUM_LINES = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_address,
  input  logic [31:0]  cpu_writedata,
  output logic [31:0]  cpu_readdata,
  output logic         cpu_busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait,
  output logic [1:0]   state_debug
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags   [NUM_LINES];
  logic [127:0]         blocks [NUM_LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         word_sel;
  logic [6:0]         word_lsb;
  logic               read_req;
  logic               write_req;
  logic               req;
  logic               hit;
  logic [31:0]        sel_word;
  logic               fill_done;
  logic               write_hit;
  logic               unused_addr_bits;

  assign req_tag  = cpu_address[31:4+INDEX_W];
  assign idx      = cpu_address[3+INDEX_W:4];
  assign word_sel = cpu_address[3:2];
  assign word_lsb = {word_sel, 5'd0};
  // Byte offset bits carry no meaning for word accesses.
  assign unused_addr_bits = &{1'b0, cpu_address[1:0]};

  // Read and write together are treated as no request at all.
  assign read_req  = cpu_read & ~cpu_write;
  assign write_req = cpu_write & ~cpu_read;
  assign req       = read_req | write_req;

  assign hit      = (state == IDLE) && valid[idx] && (tags[idx] == req_tag);
  assign sel_word = blocks[idx][word_lsb +: 32];

  assign write_hit = write_req && hit;
  assign fill_done = (state == ALLOCATE) && !mem_busywait;

  assign cpu_busywait = (req && !hit) || (state != IDLE);
  assign cpu_readdata = (read_req && hit) ? sel_word : 32'd0;
  assign state_debug  = state;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and Moore memory-side outputs
  always_comb begin
    state_next    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 28'd0;
    mem_writedata = 128'd0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {tags[idx], idx};
        mem_writedata = blocks[idx];
        if (!mem_busywait) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = cpu_address[31:4];
        if (!mem_busywait) state_next = UPDATE;
      end
      UPDATE: begin
        // One settle cycle so the lookup in IDLE sees the new line.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line status bits: cleared by reset so a fill interrupted by reset
  // leaves its line invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_done) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data storage. These need no reset, because valid qualifies them.
  always_ff @(posedge clock) begin
    if (fill_done) begin
      tags[idx]   <= req_tag;
      blocks[idx] <= mem_readdata;
    end else if (write_hit) begin
      blocks[idx][word_lsb +: 32] <= cpu_writedata;
    end
  end

endmodule
